// File: rtl/qam_pkg.sv
// Shared encodings and helpers for the QAM symbol scheduler.
package qam_pkg;

    localparam logic MOD_QPSK  = 1'b0;
    localparam logic MOD_16QAM = 1'b1;

    localparam logic [1:0] BAUD_1200 = 2'd0;
    localparam logic [1:0] BAUD_2400 = 2'd1;
    localparam logic [1:0] BAUD_4800 = 2'd2;
    localparam logic [1:0] BAUD_9600 = 2'd3;

    localparam int SPB_QPSK  = 4;
    localparam int SPB_16QAM = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Clock cycles per symbol for a given baud code.
    function automatic int baud_div(input int clk_hz, input logic [1:0] code);
        return clk_hz / (1200 << code);
    endfunction

endpackage

// File: rtl/qam_baud_tick.sv
// Free-running symbol-rate counter; tick marks the last clock of each symbol period.
module qam_baud_tick
    import qam_pkg::*;
#(
    parameter int CLK_HZ = 11059200,
    parameter int DIV_W  = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [1:0] baud_rate,
    output logic       tick
);

    localparam logic [DIV_W-1:0] LAST_1200 = DIV_W'(baud_div(CLK_HZ, BAUD_1200) - 1);
    localparam logic [DIV_W-1:0] LAST_2400 = DIV_W'(baud_div(CLK_HZ, BAUD_2400) - 1);
    localparam logic [DIV_W-1:0] LAST_4800 = DIV_W'(baud_div(CLK_HZ, BAUD_4800) - 1);
    localparam logic [DIV_W-1:0] LAST_9600 = DIV_W'(baud_div(CLK_HZ, BAUD_9600) - 1);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] last;

    always_comb begin
        last = LAST_1200;
        case (baud_rate)
            BAUD_1200: last = LAST_1200;
            BAUD_2400: last = LAST_2400;
            BAUD_4800: last = LAST_4800;
            BAUD_9600: last = LAST_9600;
        endcase
    end

    assign tick = (count == last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/qam_symbol_scheduler.sv
// Byte-to-symbol scheduler for the QAM modulator: holding register, symbol shifter,
// idle/run control and idle-only application of modulation and baud settings.
module qam_symbol_scheduler
    import qam_pkg::*;
#(
    parameter int CLK_HZ = 11059200,
    parameter int DIV_W  = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_mod_type,
    input  logic [1:0] cfg_baud_rate,
    input  logic       cfg_update,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] sym_out,
    output logic       sym_valid,
    output logic       sym_strobe,
    output logic       act_mod_type,
    output logic [1:0] act_baud_rate,
    output logic       cfg_pending,
    output logic       underrun
);

    localparam logic [2:0] LEFT_QPSK  = 3'(SPB_QPSK - 1);
    localparam logic [2:0] LEFT_16QAM = 3'(SPB_16QAM - 1);

    state_t     state;
    logic [7:0] hold;
    logic       hold_full;
    logic [7:0] sh;
    logic [2:0] sh_cnt;
    logic       pend_mod;
    logic [1:0] pend_baud;
    logic       tick;
    logic       accept;
    logic       apply;

    function automatic logic [3:0] top_symbol(input logic mod, input logic [7:0] b);
        return (mod == MOD_16QAM) ? b[7:4] : {2'b00, b[7:6]};
    endfunction

    function automatic logic [7:0] shift_symbol(input logic mod, input logic [7:0] b);
        return (mod == MOD_16QAM) ? {b[3:0], 4'h0} : {b[5:0], 2'b00};
    endfunction

    // Pending config blocks new input so the line drains and the update is never starved.
    assign in_ready = ~hold_full & ~cfg_pending;
    assign accept   = in_valid & in_ready;
    assign apply    = cfg_pending & (state == ST_IDLE) & ~hold_full;

    qam_baud_tick #(
        .CLK_HZ (CLK_HZ),
        .DIV_W  (DIV_W)
    ) u_baud_tick (
        .clk       (clk),
        .rst       (rst),
        .clear     (apply),
        .baud_rate (act_baud_rate),
        .tick      (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            hold          <= '0;
            hold_full     <= 1'b0;
            sh            <= '0;
            sh_cnt        <= '0;
            sym_out       <= '0;
            sym_valid     <= 1'b0;
            sym_strobe    <= 1'b0;
            underrun      <= 1'b0;
            act_mod_type  <= MOD_QPSK;
            act_baud_rate <= BAUD_1200;
            pend_mod      <= MOD_QPSK;
            pend_baud     <= BAUD_1200;
            cfg_pending   <= 1'b0;
        end else begin
            sym_strobe <= tick;
            underrun   <= 1'b0;

            if (accept) begin
                hold      <= in_data;
                hold_full <= 1'b1;
            end

            if (tick) begin
                if (sh_cnt != 3'd0) begin
                    sym_out   <= top_symbol(act_mod_type, sh);
                    sym_valid <= 1'b1;
                    sh        <= shift_symbol(act_mod_type, sh);
                    sh_cnt    <= sh_cnt - 3'd1;
                end else if (hold_full) begin
                    // Load and emit the first symbol of the held byte in the same tick.
                    sym_out   <= top_symbol(act_mod_type, hold);
                    sym_valid <= 1'b1;
                    sh        <= shift_symbol(act_mod_type, hold);
                    sh_cnt    <= (act_mod_type == MOD_16QAM) ? LEFT_16QAM : LEFT_QPSK;
                    hold_full <= 1'b0;
                    state     <= ST_RUN;
                end else begin
                    sym_out   <= 4'h0;
                    sym_valid <= 1'b0;
                    if (state == ST_RUN) begin
                        underrun <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
            end

            if (apply) begin
                act_mod_type  <= pend_mod;
                act_baud_rate <= pend_baud;
                cfg_pending   <= 1'b0;
            end

            // A capture in the apply cycle wins, keeping the newer request pending.
            if (cfg_update) begin
                pend_mod    <= cfg_mod_type;
                pend_baud   <= cfg_baud_rate;
                cfg_pending <= 1'b1;
            end
        end
    end

endmodule
